// File: rtl/warp_pkg.sv
// Shared definitions for the warp ready/valid building blocks.
//   WARP_HS_*      : handshake signal levels
//   WARP_ARB_N_MAX : largest supported arbiter fan-in
//   warp_clog2     : ceil(log2(v)), minimum 1, for sizing index fields
package warp_pkg;

    localparam logic WARP_HS_IDLE   = 1'b0;
    localparam logic WARP_HS_ACTIVE = 1'b1;

    localparam int unsigned WARP_ARB_N_MAX = 64;

    // Index width for v entries; never returns 0 so fields stay legal.
    function automatic int unsigned warp_clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/warp_rr_pick.sv
// Combinational rotate-priority encoder.
//   req_i : request vector
//   ptr_i : highest-priority index; search runs ptr, ptr+1, ... mod N
//   gnt_o : one-hot grant (zero when no request)
//   idx_o : binary index of the grant
//   any_o : at least one request present
module warp_rr_pick
    import warp_pkg::*;
#(
    parameter  int unsigned N   = 4,
    localparam int unsigned IDW = warp_clog2(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [N-1:0]   gnt_o,
    output logic [IDW-1:0] idx_o,
    output logic           any_o
);

    int unsigned k;

    // First request found walking forward from the pointer wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        k     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            k = (32'(ptr_i) + i) % N;
            if (!any_o && req_i[k]) begin
                any_o    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = IDW'(k);
            end
        end
    end

endmodule

// File: rtl/warp_rr_arbiter.sv
// N-way round-robin arbiter onto one registered ready/valid output stage.
// Optional macro WARP_ARB_LOCK_EN: once a requester starts a packet (beat with
// last=0) it owns the channel until its last beat; otherwise arbitration is per beat.
// Ports:
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_input_valid    : per-requester valid
//   o_input_ready    : per-requester ready, at most one bit set
//   i_input_data     : requester k payload at [k*WIDTH +: WIDTH]
//   i_input_last     : per-requester last-beat flag
//   o_output_valid   : registered output valid
//   i_output_ready   : downstream ready
//   o_output_data    : registered payload
//   o_output_last    : registered last flag
//   o_output_id      : registered source index
module warp_rr_arbiter
    import warp_pkg::*;
#(
    parameter  int unsigned N     = 4,
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned IDW   = warp_clog2(N)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [N-1:0]         i_input_valid,
    output logic [N-1:0]         o_input_ready,
    input  logic [N*WIDTH-1:0]   i_input_data,
    input  logic [N-1:0]         i_input_last,
    output logic                 o_output_valid,
    input  logic                 i_output_ready,
    output logic [WIDTH-1:0]     o_output_data,
    output logic                 o_output_last,
    output logic [IDW-1:0]       o_output_id
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_last_q,  out_last_d;
    logic [IDW-1:0]   out_id_q,    out_id_d;
    logic [IDW-1:0]   ptr_q,       ptr_d;

    logic [N-1:0]     eligible;
    logic [N-1:0]     gnt;
    logic [IDW-1:0]   pick_idx;
    logic             pick_any;
    logic             can_accept;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;
    logic [IDW-1:0]   ptr_next;

`ifdef WARP_ARB_LOCK_EN
    logic             lock_q,  lock_d;
    logic [IDW-1:0]   owner_q, owner_d;

    // While a packet is open only its owner may compete.
    always_comb begin
        eligible = i_input_valid;
        if (lock_q) begin
            eligible = i_input_valid & (N'(1) << owner_q);
        end
    end
`else
    assign eligible = i_input_valid;
`endif

    warp_rr_pick #(
        .N (N)
    ) u_pick (
        .req_i (eligible),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Output register frees up when empty or draining this cycle.
    assign can_accept = !out_valid_q || (i_output_ready == WARP_HS_ACTIVE);
    // Gating with reset keeps ready low while the block is held in reset.
    assign xfer       = can_accept && pick_any && i_rst_n;
    assign o_input_ready = gnt & {N{xfer}};

    assign sel_data = i_input_data[32'(pick_idx)*WIDTH +: WIDTH];
    assign sel_last = i_input_last[pick_idx];
    assign ptr_next = (32'(pick_idx) == N - 1) ? '0 : pick_idx + IDW'(1);

    // Next-state for the output stage, pointer and packet lock.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_id_d    = out_id_q;
        ptr_d       = ptr_q;
`ifdef WARP_ARB_LOCK_EN
        lock_d      = lock_q;
        owner_d     = owner_q;
`endif
        if (xfer) begin
            out_valid_d = WARP_HS_ACTIVE;
            out_data_d  = sel_data;
            out_last_d  = sel_last;
            out_id_d    = pick_idx;
`ifdef WARP_ARB_LOCK_EN
            // Pointer only moves past a requester once its packet closes.
            if (sel_last) begin
                lock_d = 1'b0;
                ptr_d  = ptr_next;
            end else begin
                lock_d  = 1'b1;
                owner_d = pick_idx;
            end
`else
            ptr_d = ptr_next;
`endif
        end else if (i_output_ready == WARP_HS_ACTIVE) begin
            out_valid_d = WARP_HS_IDLE;
        end
    end

    // State registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_valid_q <= WARP_HS_IDLE;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_id_q    <= '0;
            ptr_q       <= '0;
`ifdef WARP_ARB_LOCK_EN
            lock_q      <= 1'b0;
            owner_q     <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_id_q    <= out_id_d;
            ptr_q       <= ptr_d;
`ifdef WARP_ARB_LOCK_EN
            lock_q      <= lock_d;
            owner_q     <= owner_d;
`endif
        end
    end

    assign o_output_valid = out_valid_q;
    assign o_output_data  = out_data_q;
    assign o_output_last  = out_last_q;
    assign o_output_id    = out_id_q;

endmodule
